arbiter_input_conditioner: RTL

Front-end conditioner for the two raw player push-buttons of the arbiter game. It synchronises each active-low button to clk and debounces it. It then drives clean active-low levels into the game core's player_1_in_n / player_2_in_n inputs. It also provides one-cycle press strobes and a stuck-button flag for board-level diagnostics.

---
 rtl/arbiter_input_conditioner.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/arbiter_input_conditioner.sv
// Push-button front end for the arbiter game. Each button is synchronised and debounced,
// then produces a clean active-low level, a one-cycle press strobe and a stuck flag.
//
// state       | meaning
// ------------+--------------------------------------------------
// ST_RELEASED | debounced level high, waiting for a debounced press
// ST_PRESSED  | debounced level low, stuck timer running
// ST_STUCK    | debounced level low for STUCK_COUNT cycles or more
module arbiter_input_conditioner #(
    parameter int CLOCK_FREQ     = 1000,
    parameter int DEBOUNCE_COUNT = CLOCK_FREQ / 50,
    parameter int STUCK_COUNT    = CLOCK_FREQ * 4
) (
    input  logic clk,
    input  logic rst_in_n,
    input  logic btn_1_raw_n,
    input  logic btn_2_raw_n,
    output logic player_1_out_n,
    output logic player_2_out_n,
    output logic press_1_out,
    output logic press_2_out,
    output logic stuck_out
);

    localparam int DW = $clog2(DEBOUNCE_COUNT + 1);
    localparam int SW = $clog2(STUCK_COUNT + 1);

    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_COUNT - 1);
    localparam logic [SW-1:0] ST_LAST  = SW'(STUCK_COUNT - 1);
    localparam logic [SW-1:0] ST_MAX   = SW'(STUCK_COUNT);

    localparam logic [1:0] ST_RELEASED = 2'd0;
    localparam logic [1:0] ST_PRESSED  = 2'd1;
    localparam logic [1:0] ST_STUCK    = 2'd2;

    if (CLOCK_FREQ < 1 || DEBOUNCE_COUNT < 1 || STUCK_COUNT <= DEBOUNCE_COUNT) begin : g_bad_params
        $error("arbiter_input_conditioner: illegal timing parameters");
    end

    logic [1:0]    btn_raw_n;
    logic [1:0]    sync1_q, sync1_d;
    logic [1:0]    sync2_q, sync2_d;
    logic [1:0]    out_n_q, out_n_d;
    logic [1:0]    press_q, press_d;
    logic [1:0]    stuck_q, stuck_d;
    logic [1:0]    db_done;
    logic [1:0]    state_q     [2];
    logic [1:0]    state_d     [2];
    logic [DW-1:0] db_cnt_q    [2];
    logic [DW-1:0] db_cnt_d    [2];
    logic [SW-1:0] stuck_cnt_q [2];
    logic [SW-1:0] stuck_cnt_d [2];

    assign btn_raw_n = {btn_2_raw_n, btn_1_raw_n};

    always_comb begin
        sync1_d = btn_raw_n;
        sync2_d = sync1_q;
        out_n_d = out_n_q;
        press_d = 2'b00;
        stuck_d = stuck_q;
        db_done = 2'b00;
        for (int ch = 0; ch < 2; ch++) begin
            state_d[ch]     = state_q[ch];
            db_cnt_d[ch]    = db_cnt_q[ch];
            stuck_cnt_d[ch] = stuck_cnt_q[ch];

            // Any cycle agreeing with the debounced level restarts the debounce window.
            if (sync2_q[ch] == out_n_q[ch]) begin
                db_cnt_d[ch] = '0;
            end else if (db_cnt_q[ch] == DB_LAST) begin
                db_cnt_d[ch] = '0;
                db_done[ch]  = 1'b1;
            end else begin
                db_cnt_d[ch] = db_cnt_q[ch] + DW'(1);
            end

            case (state_q[ch])
                ST_RELEASED: begin
                    if (db_done[ch]) begin
                        state_d[ch] = ST_PRESSED;
                        out_n_d[ch] = 1'b0;
                        press_d[ch] = 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (db_done[ch]) begin
                        state_d[ch]     = ST_RELEASED;
                        out_n_d[ch]     = 1'b1;
                        stuck_cnt_d[ch] = '0;
                    end else if (stuck_cnt_q[ch] == ST_LAST) begin
                        state_d[ch]     = ST_STUCK;
                        stuck_cnt_d[ch] = ST_MAX;
                        stuck_d[ch]     = 1'b1;
                    end else begin
                        stuck_cnt_d[ch] = stuck_cnt_q[ch] + SW'(1);
                    end
                end
                ST_STUCK: begin
                    if (db_done[ch]) begin
                        state_d[ch]     = ST_RELEASED;
                        out_n_d[ch]     = 1'b1;
                        stuck_cnt_d[ch] = '0;
                        stuck_d[ch]     = 1'b0;
                    end
                end
                default: begin
                    state_d[ch]     = ST_RELEASED;
                    out_n_d[ch]     = 1'b1;
                    stuck_cnt_d[ch] = '0;
                    stuck_d[ch]     = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_in_n) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
            out_n_q <= 2'b11;
            press_q <= 2'b00;
            stuck_q <= 2'b00;
            for (int ch = 0; ch < 2; ch++) begin
                state_q[ch]     <= ST_RELEASED;
                db_cnt_q[ch]    <= '0;
                stuck_cnt_q[ch] <= '0;
            end
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            out_n_q <= out_n_d;
            press_q <= press_d;
            stuck_q <= stuck_d;
            for (int ch = 0; ch < 2; ch++) begin
                state_q[ch]     <= state_d[ch];
                db_cnt_q[ch]    <= db_cnt_d[ch];
                stuck_cnt_q[ch] <= stuck_cnt_d[ch];
            end
        end
    end

    assign player_1_out_n = out_n_q[0];
    assign player_2_out_n = out_n_q[1];
    assign press_1_out    = press_q[0];
    assign press_2_out    = press_q[1];
    assign stuck_out      = |stuck_q;

endmodule
